// File: rtl/pe_array_skew_feeder.sv
// pe_array_skew_feeder
//
// Operand feeder for the DSP PE array. It accepts a tile of NUM_VEC operand
// vectors of NUM_LANE lanes each. Every lane is delayed by its systolic skew
// before it drives the array. After the last skewed element has left, the
// block raises a one-cycle done.
//
// Ports
//   clk_p        : clock, all logic on the rising edge
//   rst_p        : synchronous active-high reset
//   start        : begin a tile (sampled only in IDLE)
//   r_c_sel      : skew direction, latched with start
//                  (0: lane i delayed i, 1: lane i delayed NUM_LANE-1-i)
//   in_valid     : input beat valid
//   in_ready     : block accepts a beat (high only in FEED)
//   in_data      : NUM_LANE lanes, lane i at [i*WIDTH_DATA +: WIDTH_DATA]
//   out_data     : skewed lanes, same packing; lanes without valid read 0
//   out_lane_vd  : per-lane element valid
//   vd           : OR of out_lane_vd
//   busy         : state is not IDLE
//   done         : one-cycle pulse in the cycle the final element is emitted
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on state. The source may hold in_valid high while
// in_ready is low; nothing is taken in that case.
//
// NUM_LANE must be >= 2 and NUM_VEC must be >= 1.

module pe_array_skew_feeder #(
  parameter int NUM_LANE   = 64,
  parameter int WIDTH_DATA = 8,
  parameter int NUM_VEC    = 16
) (
  input  logic                           clk_p,
  input  logic                           rst_p,
  input  logic                           start,
  input  logic                           r_c_sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANE*WIDTH_DATA-1:0] in_data,
  output logic [NUM_LANE*WIDTH_DATA-1:0] out_data,
  output logic [NUM_LANE-1:0]            out_lane_vd,
  output logic                           vd,
  output logic                           busy,
  output logic                           done
);

  localparam int BEAT_W    = $clog2(NUM_VEC + 1);
  localparam int DRAIN_W   = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam int CHAIN_LEN = (NUM_LANE > 1) ? NUM_LANE - 1 : 1;

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(NUM_VEC - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(NUM_LANE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // state_q is the observable FSM state for checkers
  state_t               state_q;
  logic                 mode_q;
  logic [BEAT_W-1:0]    beat_cnt_q;
  logic [DRAIN_W-1:0]   drain_cnt_q;

  // Per-lane delay chains. Stage j of lane i holds an element that was
  // accepted j+1 edges ago.
  logic [WIDTH_DATA-1:0] chain_d_q [NUM_LANE][CHAIN_LEN];
  logic                  chain_v_q [NUM_LANE][CHAIN_LEN];

  // taps[i][j] is the element that has been delayed j cycles on lane i;
  // tap 0 is the (bubble-gated) input itself.
  logic [WIDTH_DATA-1:0] taps_d [NUM_LANE][NUM_LANE];
  logic                  taps_v [NUM_LANE][NUM_LANE];

  logic [WIDTH_DATA-1:0] out_d_q [NUM_LANE];

  logic accept;

  assign in_ready = (state_q == S_FEED);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DRAIN) && (drain_cnt_q == LAST_DRAIN);
  assign vd       = |out_lane_vd;

  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) begin
      // A cycle without an accepted beat enters the chain as a zero bubble,
      // which is why invalid lanes read 0 at the output.
      taps_d[i][0] = accept ? in_data[i*WIDTH_DATA +: WIDTH_DATA] : '0;
      taps_v[i][0] = accept;
      for (int j = 1; j < NUM_LANE; j++) begin
        taps_d[i][j] = chain_d_q[i][j-1];
        taps_v[i][j] = chain_v_q[i][j-1];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      out_data[i*WIDTH_DATA +: WIDTH_DATA] = out_d_q[i];
    end
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      out_lane_vd <= '0;
      for (int i = 0; i < NUM_LANE; i++) begin
        out_d_q[i] <= '0;
        for (int j = 0; j < CHAIN_LEN; j++) begin
          chain_d_q[i][j] <= '0;
          chain_v_q[i][j] <= 1'b0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q     <= r_c_sel;
            beat_cnt_q <= '0;
            state_q    <= S_FEED;
          end
        end
        S_FEED: begin
          if (accept) begin
            if (beat_cnt_q == LAST_BEAT) begin
              drain_cnt_q <= '0;
              state_q     <= S_DRAIN;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // The farthest lane needs NUM_LANE cycles after the last accept.
          if (drain_cnt_q == LAST_DRAIN) begin
            state_q <= S_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Chains advance every cycle regardless of state.
      for (int i = 0; i < NUM_LANE; i++) begin
        for (int j = 0; j < NUM_LANE - 1; j++) begin
          chain_d_q[i][j] <= taps_d[i][j];
          chain_v_q[i][j] <= taps_v[i][j];
        end
        // The output register picks the tap matching this lane's skew.
        // mode_q only changes in IDLE, after the previous tile has drained.
        out_d_q[i]     <= mode_q ? taps_d[i][NUM_LANE-1-i] : taps_d[i][i];
        out_lane_vd[i] <= mode_q ? taps_v[i][NUM_LANE-1-i] : taps_v[i][i];
      end
    end
  end

endmodule

// File: tb/tb_pe_array_skew_feeder.sv
module tb_pe_array_skew_feeder;

  localparam int NUM_LANE   = 4;
  localparam int WIDTH_DATA = 8;
  localparam int NUM_VEC    = 3;
  localparam int DW         = NUM_LANE * WIDTH_DATA;

  localparam logic [DW-1:0] BEAT0 = 32'h13121110;
  localparam logic [DW-1:0] BEAT1 = 32'h23222120;
  localparam logic [DW-1:0] BEAT2 = 32'h33323130;
  localparam logic [DW-1:0] JUNK  = 32'hDEADBEEF;

  logic                clk_p;
  logic                rst_p;
  logic                start;
  logic                r_c_sel;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_data;
  logic [DW-1:0]       out_data;
  logic [NUM_LANE-1:0] out_lane_vd;
  logic                vd;
  logic                busy;
  logic                done;

  int checks;
  int errors;

  pe_array_skew_feeder #(
    .NUM_LANE   (NUM_LANE),
    .WIDTH_DATA (WIDTH_DATA),
    .NUM_VEC    (NUM_VEC)
  ) dut (
    .clk_p       (clk_p),
    .rst_p       (rst_p),
    .start       (start),
    .r_c_sel     (r_c_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_data    (out_data),
    .out_lane_vd (out_lane_vd),
    .vd          (vd),
    .busy        (busy),
    .done        (done)
  );

  // clock / reset
  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  // driver tasks
  task automatic drive_idle();
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = JUNK;
  endtask

  task automatic drive_beat(input logic [DW-1:0] data);
    in_valid = 1'b1;
    in_data  = data;
  endtask

  // Issue start and step into the first FEED cycle.
  task automatic issue_start(input logic mode);
    start   = 1'b1;
    r_c_sel = mode;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst_p    = 1'b1;
    start    = 1'b1;
    r_c_sel  = 1'b0;
    in_valid = 1'b1;
    in_data  = JUNK;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({out_data, out_lane_vd, vd, busy, done, in_ready} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: data=%h lane_vd=%b vd=%b busy=%b done=%b in_ready=%b want all 0",
                 c, out_data, out_lane_vd, vd, busy, done, in_ready);
      end
    end
    rst_p = 1'b0;
    drive_idle();
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_mode_forward();
    logic [DW-1:0]       exp_d [7];
    logic [NUM_LANE-1:0] exp_v [7];
    logic                exp_done [7];
    exp_d    = '{32'h00000010, 32'h00001120, 32'h00122130, 32'h13223100,
                 32'h23320000, 32'h33000000, 32'h00000000};
    exp_v    = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
    exp_done = '{0, 0, 0, 0, 0, 1, 0};
    issue_start(1'b0);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fwd_feed_entry: in_ready=%b busy=%b want 1 1", in_ready, busy);
    end
    for (int c = 0; c < 7; c++) begin
      drive_idle();
      if (c == 0) drive_beat(BEAT0);
      if (c == 1) drive_beat(BEAT1);
      if (c == 2) drive_beat(BEAT2);
      tick();
      checks++;
      if (out_data !== exp_d[c] || out_lane_vd !== exp_v[c] || vd !== (exp_v[c] != 0)) begin
        errors++;
        $display("FAIL fwd_lanes row %0d: data=%h vd=%b/%b want %h %b", c, out_data, out_lane_vd, vd,
                 exp_d[c], exp_v[c]);
      end
      checks++;
      if (done !== exp_done[c] || busy !== (c < 6)) begin
        errors++;
        $display("FAIL fwd_ctrl row %0d: done=%b busy=%b want %b %b", c, done, busy, exp_done[c], c < 6);
      end
    end
  endtask

  task automatic test_mode_reverse();
    logic [DW-1:0]       exp_d [7];
    logic [NUM_LANE-1:0] exp_v [7];
    exp_d = '{32'h13000000, 32'h23120000, 32'h33221100, 32'h00322110,
              32'h00003120, 32'h00000030, 32'h00000000};
    exp_v = '{4'h8, 4'hC, 4'hE, 4'h7, 4'h3, 4'h1, 4'h0};
    issue_start(1'b1);
    for (int c = 0; c < 7; c++) begin
      drive_idle();
      if (c == 0) drive_beat(BEAT0);
      if (c == 1) drive_beat(BEAT1);
      if (c == 2) drive_beat(BEAT2);
      tick();
      checks++;
      if (out_data !== exp_d[c] || out_lane_vd !== exp_v[c]) begin
        errors++;
        $display("FAIL rev_lanes row %0d: data=%h vd=%b want %h %b", c, out_data, out_lane_vd,
                 exp_d[c], exp_v[c]);
      end
      checks++;
      if (done !== (c == 5) || busy !== (c < 6)) begin
        errors++;
        $display("FAIL rev_ctrl row %0d: done=%b busy=%b want %b %b", c, done, busy, c == 5, c < 6);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [DW-1:0]       exp_d [9];
    logic [NUM_LANE-1:0] exp_v [9];
    exp_d = '{32'h00000010, 32'h00001120, 32'h00122100, 32'h13220000, 32'h23000030,
              32'h00003100, 32'h00320000, 32'h33000000, 32'h00000000};
    exp_v = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h0};
    issue_start(1'b0);
    for (int c = 0; c < 9; c++) begin
      drive_idle();
      if (c == 0) drive_beat(BEAT0);
      if (c == 1) drive_beat(BEAT1);
      if (c == 4) drive_beat(BEAT2);
      tick();
      checks++;
      if (out_data !== exp_d[c] || out_lane_vd !== exp_v[c]) begin
        errors++;
        $display("FAIL bubble_lanes row %0d: data=%h vd=%b want %h %b", c, out_data, out_lane_vd,
                 exp_d[c], exp_v[c]);
      end
      checks++;
      if (done !== (c == 7) || busy !== (c < 8) || in_ready !== (c < 4)) begin
        errors++;
        $display("FAIL bubble_ctrl row %0d: done=%b busy=%b in_ready=%b want %b %b %b", c, done, busy,
                 in_ready, c == 7, c < 8, c < 4);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [DW-1:0] exp_d [8];
    int            done_count;
    exp_d = '{32'h00000010, 32'h00001120, 32'h00122130, 32'h13223100,
              32'h23320000, 32'h33000000, 32'h00000000, 32'h00000000};
    done_count = 0;
    issue_start(1'b0);
    for (int c = 0; c < 8; c++) begin
      drive_idle();
      r_c_sel = 1'b0;
      if (c == 0) drive_beat(BEAT0);
      if (c == 1) drive_beat(BEAT1);
      if (c == 2) drive_beat(BEAT2);
      // pulses in FEED, in DRAIN and in the done cycle
      if (c == 1 || c == 4 || c == 5) begin
        start   = 1'b1;
        r_c_sel = 1'b1;
      end
      tick();
      if (done === 1'b1) done_count++;
      checks++;
      if (out_data !== exp_d[c]) begin
        errors++;
        $display("FAIL ign_start_lanes row %0d: data=%h want %h", c, out_data, exp_d[c]);
      end
    end
    checks++;
    if (done_count != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_start_end: done_count=%0d busy=%b want 1 0", done_count, busy);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_drain();
    issue_start(1'b0);
    for (int c = 0; c < 7; c++) begin
      drive_idle();
      if (c == 0) drive_beat(BEAT0);
      if (c == 1) drive_beat(BEAT1);
      if (c == 2) drive_beat(BEAT2);
      rst_p = (c == 4);
      tick();
      if (c == 3) begin
        checks++;
        if (out_data !== 32'h13223100) begin
          errors++;
          $display("FAIL rst_drain_pre: data=%h want 13223100", out_data);
        end
      end
      if (c >= 4) begin
        checks++;
        if (out_lane_vd !== '0 || out_data !== '0 || done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rst_drain_row %0d: data=%h vd=%b done=%b busy=%b want 0", c, out_data,
                   out_lane_vd, done, busy);
        end
      end
    end
    rst_p = 1'b0;
    test_mode_reverse();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_p    = 1'b0;
    start    = 1'b0;
    r_c_sel  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_mode_forward();
    test_mode_reverse();
    test_bubbles();
    test_ignored_start();
    test_reset_mid_drain();
    // back-to-back tiles with minimum spacing
    test_mode_forward();
    test_mode_reverse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
